frog_anim_gen: RTL and testbench
================================

FROG_ANIM_GEN -- requirements
Module: frog_anim_gen

Interface
REQ-001 SHALL have parameter SPRITE_LOG2, default 5, meaning sprite source is 2^SPRITE_LOG2 pixels square.
REQ-002 SHALL have parameter SCALE_SHIFT, default 0 (legal 0..2), meaning on-screen size = 2^(SPRITE_LOG2+SCALE_SHIFT).
REQ-003 SHALL have parameter HOP_TICKS, default 8, meaning frame ticks spent in the jump pose per hop.
REQ-004 SHALL have parameter DEATH_TICKS, default 6, meaning frame ticks per death-animation pose.
REQ-005 SHALL have ports: clk in 1 pixel clock; rst_n in 1 synchronous active-low reset.
REQ-006 SHALL have ports: colPos in 10 and rowPos in 10, the current raster pixel.
REQ-007 SHALL have ports: frog_x in 10 and frog_y in 10, requested top-left position; facing in 2 (0 up, 1 right, 2 down, 3 left).
REQ-008 SHALL have ports: frame_tick in 1, one-cycle pulse per video frame.
REQ-009 SHALL have ports: hop_start in 1, die in 1 and revive in 1, all one-cycle command pulses.
REQ-010 SHALL have ports: color out 6 (RRGGBB); opaque out 1, pixel is frog and non-transparent.
REQ-011 SHALL have ports: hop_busy out 1 (state HOP) and dead out 1 (state DEAD).
REQ-012 SHALL use one clock, clk; reset rst_n is synchronous and active-low.

Function
REQ-013 SHALL implement FSM states IDLE, HOP, DEATH and DEAD.
REQ-014 SHALL transition IDLE->HOP on hop_start and HOP->IDLE after HOP_TICKS frame_ticks counted from entry.
REQ-015 SHALL transition IDLE/HOP->DEATH on die; DEATH SHALL cycle poses splat0..splat3, DEATH_TICKS frame_ticks each, then go to DEAD.
REQ-016 SHALL go from any state to IDLE on revive, with priority revive > die > hop_start when pulses coincide.
REQ-017 SHALL ignore hop_start outside IDLE and die in DEATH/DEAD; the tick counter SHALL clear on every state entry.
REQ-018 SHALL use pose 0=sit (IDLE), 1=jump (HOP), 2..5=splat0..3 (DEATH), 5 held in DEAD.
REQ-019 SHALL sample frog_x, frog_y and facing into shadow registers only on frame_tick, so that no mid-frame tearing occurs.
REQ-020 SHALL take pose and facing for the pixel path from registers that also update only on frame_tick.
REQ-021 SHALL compute in_frog with shadow position, inclusive at the start and exclusive at the end, using 11-bit arithmetic so x+size does not wrap at 1023.
REQ-022 SHALL compute local coordinates as (pos-shadow)>>SCALE_SHIFT, truncated to SPRITE_LOG2 bits.
REQ-023 SHALL form the ROM address as {pose[2:0], facing, local_y, local_x}, 5+2*SPRITE_LOG2 bits wide.
REQ-024 SHALL have a pixel latency of exactly 2 clk from colPos/rowPos to color/opaque: 1 cycle for the synchronous ROM and 1 for the output register.
REQ-025 SHALL drive color to the ROM data and opaque=1 when in_frog is set and the ROM data is not 6'b000000 (transparent key); otherwise it SHALL drive color=0 and opaque=0.
REQ-026 SHALL delay in_frog through the pipeline alongside the address.

Reset
REQ-027 SHALL, with rst_n low at a clk edge, set the state to IDLE, the tick counter to 0, shadows to 0 and pose to 0.
REQ-028 SHALL, under the same reset condition, clear color, opaque, hop_busy and dead to 0 and clear the pipeline valid bits.
REQ-029 SHALL abort any animation on a mid-animation reset; the first frame after release SHALL show sit.

Structure
REQ-030 SHALL place color constants, TRANSPARENT=6'b000000, the anim_state_t enum and pose encodings in package frog_pkg.
REQ-031 SHALL instantiate exactly one sub-module, frog_anim_rom: a registered-output ROM with 6 poses x 4 facings, loaded from a mem file.

Verification
REQ-032 SHALL test: frog_x=100, frog_y=200, frame_tick, then raster at (100,200) -> in_frog, with color at cycle +2 equal to ROM[{0,0,0,0}].
REQ-033 SHALL test: hop_start in IDLE -> hop_busy=1 for exactly 8 frame_ticks, then 0; pose 1 during the hop, 0 after it.
REQ-034 SHALL test: die and hop_start in the same cycle -> DEATH; after 24 frame_ticks dead=1 and pose 5 is held.
REQ-035 SHALL test: revive during DEATH tick 3 -> IDLE at the next clk; a subsequent die restarts at splat0.
REQ-036 SHALL test: SCALE_SHIFT=1, frog_x=1000 -> pixels 1000..1023 drawn, no wrap to column 0, and local_x equals col[5:1] offset.
REQ-037 SHALL test: frog_x changed mid-frame -> output unchanged until the next frame_tick; rst_n low mid-HOP -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared types and constants for the frog sprite animation block.
package frog_pkg;

    localparam logic [5:0] TRANSPARENT = 6'b000000;
    localparam logic [5:0] COLOR_BLACK = 6'b000000;

    typedef enum logic [1:0] {StIdle, StHop, StDeath, StDead} anim_state_t;

    typedef logic [2:0] pose_t;
    localparam pose_t POSE_SIT    = 3'd0;
    localparam pose_t POSE_JUMP   = 3'd1;
    localparam pose_t POSE_SPLAT0 = 3'd2;
    localparam pose_t POSE_SPLAT3 = 3'd5;

    function automatic pose_t pose_of(input anim_state_t st, input logic [1:0] splat);
        pose_t p;
        case (st)
            StIdle:  p = POSE_SIT;
            StHop:   p = POSE_JUMP;
            StDeath: p = POSE_SPLAT0 + pose_t'(splat);
            default: p = POSE_SPLAT3;
        endcase
        return p;
    endfunction

    // Sprite artwork: folded local coordinates XORed with a pose/facing tag.
    // Local (0,0) of every image yields {pose, facing, 1}.
    function automatic logic [5:0] sprite_pixel(input pose_t pose, input logic [1:0] facing,
                                                input logic [2:0] x3, input logic [2:0] y3);
        return {pose, facing, 1'b1} ^ {x3, y3};
    endfunction

endpackage

// File: rtl/frog_anim_gen_if.sv
// Raster, position, command and pixel-output signals of the frog animation generator.
interface frog_anim_gen_if;
    logic [9:0] colPos;
    logic [9:0] rowPos;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic [1:0] facing;
    logic       frame_tick;
    logic       hop_start;
    logic       die;
    logic       revive;
    logic [5:0] color;
    logic       opaque;
    logic       hop_busy;
    logic       dead;

    modport master (
        output colPos, rowPos, frog_x, frog_y, facing, frame_tick, hop_start, die, revive,
        input  color, opaque, hop_busy, dead
    );

    modport slave (
        input  colPos, rowPos, frog_x, frog_y, facing, frame_tick, hop_start, die, revive,
        output color, opaque, hop_busy, dead
    );
endinterface

// File: rtl/frog_anim_rom.sv
// Registered-output sprite ROM: 6 poses x 4 facings of 2^SPRITE_LOG2 square images.
module frog_anim_rom
    import frog_pkg::*;
#(
    parameter int unsigned SPRITE_LOG2 = 5
) (
    input  logic                       clk,
    input  logic [4+2*SPRITE_LOG2:0]   addr,
    output logic [5:0]                 data
);

    pose_t                  pose;
    logic [1:0]             facing;
    logic [SPRITE_LOG2-1:0] lx;
    logic [SPRITE_LOG2-1:0] ly;
    logic [2:0]             x3;
    logic [2:0]             y3;

    assign pose   = addr[4+2*SPRITE_LOG2 -: 3];
    assign facing = addr[2*SPRITE_LOG2+1 -: 2];
    assign ly     = addr[2*SPRITE_LOG2-1 -: SPRITE_LOG2];
    assign lx     = addr[SPRITE_LOG2-1:0];

    assign x3 = 3'(lx) ^ 3'(lx >> 3);
    assign y3 = 3'(ly) ^ 3'(ly >> 3);

    always_ff @(posedge clk) begin
        data <= sprite_pixel(pose, facing, x3, y3);
    end

endmodule

// File: rtl/frog_anim_gen.sv
// Frog sprite generator: hop/death animation FSM plus a 2-cycle raster pixel pipeline.
module frog_anim_gen
    import frog_pkg::*;
#(
    parameter int unsigned SPRITE_LOG2 = 5,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned HOP_TICKS   = 8,
    parameter int unsigned DEATH_TICKS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    frog_anim_gen_if.slave  bus
);

    localparam int unsigned MAX_TICKS = (HOP_TICKS > DEATH_TICKS) ? HOP_TICKS : DEATH_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int unsigned SIZE      = 1 << (SPRITE_LOG2 + SCALE_SHIFT);
    localparam int unsigned AW        = 5 + 2 * SPRITE_LOG2;

    anim_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       splat_q, splat_d;
    pose_t            pose_d;

    pose_t      pose_frame_q;
    logic [1:0] facing_sh_q;
    logic [9:0] x_sh_q;
    logic [9:0] y_sh_q;
    logic       hop_busy_q;
    logic       dead_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        splat_d = splat_q;
        if (bus.revive) begin
            state_d = StIdle;
            cnt_d   = '0;
            splat_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.die) begin
                        state_d = StDeath;
                        cnt_d   = '0;
                        splat_d = '0;
                    end else if (bus.hop_start) begin
                        state_d = StHop;
                        cnt_d   = '0;
                    end
                end
                StHop: begin
                    if (bus.die) begin
                        state_d = StDeath;
                        cnt_d   = '0;
                        splat_d = '0;
                    end else if (bus.frame_tick) begin
                        if (cnt_q == CNT_W'(HOP_TICKS - 1)) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StDeath: begin
                    if (bus.frame_tick) begin
                        if (cnt_q == CNT_W'(DEATH_TICKS - 1)) begin
                            cnt_d = '0;
                            if (splat_q == 2'd3) begin
                                state_d = StDead;
                            end else begin
                                splat_d = splat_q + 2'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StDead: ;
                default: state_d = StIdle;
            endcase
        end
    end

    assign pose_d = pose_of(state_d, splat_d);

    // Pose, facing and position seen by the pixel path only move on frame_tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            splat_q      <= '0;
            hop_busy_q   <= 1'b0;
            dead_q       <= 1'b0;
            pose_frame_q <= POSE_SIT;
            facing_sh_q  <= '0;
            x_sh_q       <= '0;
            y_sh_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            splat_q    <= splat_d;
            hop_busy_q <= (state_d == StHop);
            dead_q     <= (state_d == StDead);
            if (bus.frame_tick) begin
                pose_frame_q <= pose_d;
                facing_sh_q  <= bus.facing;
                x_sh_q       <= bus.frog_x;
                y_sh_q       <= bus.frog_y;
            end
        end
    end

    // 11-bit compares so a sprite near column/row 1023 never wraps to 0.
    logic                   in_x, in_y, in_frog;
    logic [9:0]             dx, dy;
    logic [SPRITE_LOG2-1:0] lx, ly;
    logic [AW-1:0]          rom_addr;
    logic [5:0]             rom_data;

    assign in_x = ({1'b0, bus.colPos} >= {1'b0, x_sh_q}) &&
                  ({1'b0, bus.colPos} < ({1'b0, x_sh_q} + 11'(SIZE)));
    assign in_y = ({1'b0, bus.rowPos} >= {1'b0, y_sh_q}) &&
                  ({1'b0, bus.rowPos} < ({1'b0, y_sh_q} + 11'(SIZE)));
    assign in_frog = in_x && in_y;

    assign dx       = bus.colPos - x_sh_q;
    assign dy       = bus.rowPos - y_sh_q;
    assign lx       = SPRITE_LOG2'(dx >> SCALE_SHIFT);
    assign ly       = SPRITE_LOG2'(dy >> SCALE_SHIFT);
    assign rom_addr = {pose_frame_q, facing_sh_q, ly, lx};

    frog_anim_rom #(
        .SPRITE_LOG2 (SPRITE_LOG2)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    logic       in_frog_q;
    logic [5:0] color_q;
    logic       opaque_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_frog_q <= 1'b0;
            color_q   <= COLOR_BLACK;
            opaque_q  <= 1'b0;
        end else begin
            in_frog_q <= in_frog;
            if (in_frog_q && (rom_data != TRANSPARENT)) begin
                color_q  <= rom_data;
                opaque_q <= 1'b1;
            end else begin
                color_q  <= COLOR_BLACK;
                opaque_q <= 1'b0;
            end
        end
    end

    assign bus.color    = color_q;
    assign bus.opaque   = opaque_q;
    assign bus.hop_busy = hop_busy_q;
    assign bus.dead     = dead_q;

endmodule

// File: tb/tb_frog_anim_gen.sv
// Directed bench for frog_anim_gen: one unscaled and one 2x-scaled instance.
module tb_frog_anim_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    frog_anim_gen_if bus0 ();
    frog_anim_gen_if bus1 ();

    frog_anim_gen #(
        .SPRITE_LOG2 (5),
        .SCALE_SHIFT (0),
        .HOP_TICKS   (8),
        .DEATH_TICKS (6)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    frog_anim_gen #(
        .SPRITE_LOG2 (5),
        .SCALE_SHIFT (1),
        .HOP_TICKS   (8),
        .DEATH_TICKS (6)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [6:0] exp_q[$];
    string      tag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected {color, opaque} for a raster pixel, from the sprite artwork definition.
    function automatic logic [6:0] pix(input int ss, input int pose, input int facing,
                                       input int fx, input int fy, input int col, input int row);
        int size;
        int dx;
        int dy;
        logic [4:0] lx;
        logic [4:0] ly;
        logic [2:0] x3;
        logic [2:0] y3;
        logic [5:0] d;
        size = 1 << (5 + ss);
        dx = col - fx;
        dy = row - fy;
        if (dx < 0 || dx >= size || dy < 0 || dy >= size) return 7'd0;
        lx = 5'(dx >> ss);
        ly = 5'(dy >> ss);
        x3 = lx[2:0] ^ {1'b0, lx[4:3]};
        y3 = ly[2:0] ^ {1'b0, ly[4:3]};
        d  = {3'(pose) ^ x3, 2'(facing) ^ y3[2:1], ~y3[0]};
        if (d == 6'd0) return 7'd0;
        return {d, 1'b1};
    endfunction

    task automatic drive(input int col, input int row);
        bus0.colPos = 10'(col);
        bus0.rowPos = 10'(row);
        bus1.colPos = 10'(col);
        bus1.rowPos = 10'(row);
    endtask

    // One pixel in, off-sprite pixel next, compare exactly two clocks later.
    task automatic probe(input int which, input int col, input int row,
                         input logic [6:0] want, input string tag);
        logic [6:0] got;
        @(negedge clk);
        drive(col, row);
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(negedge clk);
        drive(500, 500);
        @(negedge clk);
        got = (which == 0) ? {bus0.color, bus0.opaque} : {bus1.color, bus1.opaque};
        check(tag_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
    endtask

    task automatic tick();
        @(negedge clk);
        bus0.frame_tick = 1'b1;
        bus1.frame_tick = 1'b1;
        @(negedge clk);
        bus0.frame_tick = 1'b0;
        bus1.frame_tick = 1'b0;
    endtask

    task automatic cmd(input logic hop, input logic kill, input logic rev);
        @(negedge clk);
        bus0.hop_start = hop;
        bus0.die       = kill;
        bus0.revive    = rev;
        @(negedge clk);
        bus0.hop_start = 1'b0;
        bus0.die       = 1'b0;
        bus0.revive    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(500, 500);
        bus0.frog_x = '0; bus0.frog_y = '0; bus0.facing = '0;
        bus1.frog_x = '0; bus1.frog_y = '0; bus1.facing = '0;
        bus0.frame_tick = 1'b0; bus0.hop_start = 1'b0; bus0.die = 1'b0; bus0.revive = 1'b0;
        bus1.frame_tick = 1'b0; bus1.hop_start = 1'b0; bus1.die = 1'b0; bus1.revive = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_color", 32'(bus0.color), 32'd0);
        check("reset_opaque", 32'(bus0.opaque), 32'd0);
        check("reset_hop_busy", 32'(bus0.hop_busy), 32'd0);
        check("reset_dead", 32'(bus0.dead), 32'd0);
        rst_n = 1'b1;

        // Position sampling and sprite window.
        bus0.frog_x = 10'd100; bus0.frog_y = 10'd200;
        bus1.frog_x = 10'd1000; bus1.frog_y = 10'd200;
        tick();
        probe(0, 100, 200, pix(0, 0, 0, 100, 200, 100, 200), "origin");
        probe(0, 100, 201, pix(0, 0, 0, 100, 200, 100, 201), "transparent_key");
        probe(0, 131, 200, pix(0, 0, 0, 100, 200, 131, 200), "x_last");
        probe(0, 132, 200, 7'd0, "x_end_exclusive");
        probe(0, 99, 200, 7'd0, "x_before");
        probe(0, 100, 232, 7'd0, "y_end_exclusive");
        probe(0, 120, 215, pix(0, 0, 0, 100, 200, 120, 215), "interior");

        // Scaled instance at the right screen edge.
        probe(1, 1000, 200, pix(1, 0, 0, 1000, 200, 1000, 200), "s1_x1000");
        probe(1, 1003, 200, pix(1, 0, 0, 1000, 200, 1003, 200), "s1_x1003");
        probe(1, 1023, 200, pix(1, 0, 0, 1000, 200, 1023, 200), "s1_x1023");
        probe(1, 1017, 230, pix(1, 0, 0, 1000, 200, 1017, 230), "s1_x1017_y230");
        probe(1, 0, 200, 7'd0, "s1_no_wrap");

        // Mid-frame changes must wait for the next frame_tick.
        bus0.frog_x = 10'd110;
        bus0.facing = 2'd1;
        probe(0, 100, 200, pix(0, 0, 0, 100, 200, 100, 200), "no_tear");
        tick();
        probe(0, 110, 200, pix(0, 0, 1, 110, 200, 110, 200), "new_pos_facing");
        probe(0, 100, 200, 7'd0, "old_pos_gone");

        // Hop.
        cmd(1'b1, 1'b0, 1'b0);
        check("hop_enter", 32'(bus0.hop_busy), 32'd1);
        probe(0, 110, 200, pix(0, 0, 1, 110, 200, 110, 200), "hop_frame_pending");
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("hop_busy_t%0d", i), 32'(bus0.hop_busy), (i < 8) ? 32'd1 : 32'd0);
            if (i == 1) probe(0, 110, 200, pix(0, 1, 1, 110, 200, 110, 200), "hop_pose");
            if (i == 3) cmd(1'b1, 1'b0, 1'b0);
        end
        probe(0, 110, 200, pix(0, 0, 1, 110, 200, 110, 200), "after_hop_pose");

        // Death with a coincident hop_start.
        cmd(1'b1, 1'b1, 1'b0);
        check("death_not_hop", 32'(bus0.hop_busy), 32'd0);
        check("death_not_dead", 32'(bus0.dead), 32'd0);
        for (int i = 1; i <= 24; i++) begin
            tick();
            check($sformatf("dead_t%0d", i), 32'(bus0.dead), (i == 24) ? 32'd1 : 32'd0);
            if (i == 1) probe(0, 110, 200, pix(0, 2, 1, 110, 200, 110, 200), "splat0_t1");
            if (i == 6) probe(0, 110, 200, pix(0, 3, 1, 110, 200, 110, 200), "splat1_t6");
            if (i == 12) probe(0, 110, 200, pix(0, 4, 1, 110, 200, 110, 200), "splat2_t12");
            if (i == 24) probe(0, 110, 200, pix(0, 5, 1, 110, 200, 110, 200), "dead_pose");
        end
        cmd(1'b0, 1'b1, 1'b0);
        tick();
        check("dead_held", 32'(bus0.dead), 32'd1);
        probe(0, 110, 200, pix(0, 5, 1, 110, 200, 110, 200), "dead_pose_held");

        // Revive from DEAD, then mid-DEATH.
        cmd(1'b0, 1'b0, 1'b1);
        check("revive_from_dead", 32'(bus0.dead), 32'd0);
        cmd(1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        cmd(1'b0, 1'b0, 1'b1);
        check("revive_mid_death_dead", 32'(bus0.dead), 32'd0);
        cmd(1'b1, 1'b0, 1'b0);
        check("idle_after_revive", 32'(bus0.hop_busy), 32'd1);
        cmd(1'b0, 1'b1, 1'b0);
        check("redie_not_hop", 32'(bus0.hop_busy), 32'd0);
        repeat (5) tick();
        probe(0, 110, 200, pix(0, 2, 1, 110, 200, 110, 200), "restart_splat0_t5");
        tick();
        probe(0, 110, 200, pix(0, 3, 1, 110, 200, 110, 200), "restart_splat1_t6");

        // revive beats die and hop_start.
        cmd(1'b1, 1'b1, 1'b1);
        check("prio_hop_busy", 32'(bus0.hop_busy), 32'd0);
        cmd(1'b1, 1'b0, 1'b0);
        check("prio_then_hop", 32'(bus0.hop_busy), 32'd1);

        // Reset in the middle of a hop.
        tick();
        tick();
        @(negedge clk);
        drive(110, 200);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_color", 32'(bus0.color), 32'd0);
        check("midrst_opaque", 32'(bus0.opaque), 32'd0);
        check("midrst_hop_busy", 32'(bus0.hop_busy), 32'd0);
        check("midrst_dead", 32'(bus0.dead), 32'd0);
        rst_n = 1'b1;
        drive(500, 500);
        @(negedge clk);
        check("post_rst_hop_busy", 32'(bus0.hop_busy), 32'd0);
        tick();
        probe(0, 110, 200, pix(0, 0, 1, 110, 200, 110, 200), "sit_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
